// File: rtl/regfile_scoreboard_mp.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_mp
//
// Register file for the MIPS datapath.
//   - NUM_RD combinational read ports and one synchronous write port.
//   - Register 0 always reads as zero.
//   - Per-register busy scoreboard for pipeline hazard detection.
//   - After reset, a sequencer clears one entry per cycle. ready_o rises
//     once every entry has been cleared.
//
// Optional build macro: REGFILE_BYPASS_EN
//   When defined, a read port whose index matches an in-flight write
//   (RUN state, reg_write_i=1, non-zero index) returns write_data_i in the
//   same cycle and reports not-busy. When undefined, a read port returns
//   the stored value until the clock edge.
//
// Ports
//   clk_i               sole clock, rising edge
//   rst_i               synchronous active-high reset
//   read_register_i     packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   read_data_o         packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   read_busy_o         busy bit of each addressed register
//   write_register_i    write index
//   write_data_i        write value
//   reg_write_i         write strobe; also clears the written register's busy bit
//   reserve_en_i        mark reserve_register_i busy
//   reserve_register_i  register to reserve
//   ready_o             high once initialisation has completed
// ---------------------------------------------------------------------------
module regfile_scoreboard_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   read_register_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]   read_data_o,
    output logic [NUM_RD-1:0]              read_busy_o,
    input  logic [ADDR_WIDTH-1:0]          write_register_i,
    input  logic [DATA_WIDTH-1:0]          write_data_i,
    input  logic                           reg_write_i,
    input  logic                           reserve_en_i,
    input  logic [ADDR_WIDTH-1:0]          reserve_register_i,
    output logic                           ready_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]        busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Next-state, scoreboard and array write-port selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = write_register_i;
        mem_wdata = write_data_i;

        case (state_q)
            S_INIT: begin
                // The sequencer owns the write port; user writes and
                // reservations are ignored.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (reg_write_i && (write_register_i != '0)) begin
                    mem_we                   = 1'b1;
                    busy_d[write_register_i] = 1'b0;
                end
                // Applied after the writeback clear so that a reservation of
                // the same register in the same cycle leaves it busy.
                if (reserve_en_i && (reserve_register_i != '0)) begin
                    busy_d[reserve_register_i] = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Array storage has no reset; its contents are cleared by the sequencer.
    // Writes are suppressed while reset is held so a user write in the reset
    // cycle cannot land after the clear has already passed that entry.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ready_o = (state_q == S_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ridx;
            logic [DATA_WIDTH-1:0] rdata;
            logic                  rbusy;

            assign ridx = read_register_i[gi*ADDR_WIDTH +: ADDR_WIDTH];

            always_comb begin
                rdata = '0;
                rbusy = 1'b0;
                // Outside RUN, and for register 0, the port returns zero.
                if ((state_q == S_RUN) && (ridx != '0)) begin
                    rdata = mem_q[ridx];
                    rbusy = busy_q[ridx];
`ifdef REGFILE_BYPASS_EN
                    if (reg_write_i && (write_register_i == ridx)) begin
                        rdata = write_data_i;
                        rbusy = 1'b0;
                    end
`endif
                end
            end

            assign read_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = rdata;
            assign read_busy_o[gi]                          = rbusy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_scoreboard_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard_mp
//
// Directed steps followed by a random phase. A behavioural model (array of
// register values, array of busy flags, ready flag and init-cycle count)
// is advanced once per clock edge from the inputs presented in that cycle.
// Inputs change while the clock is low; outputs are sampled 1 ns later,
// well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 4;
    localparam int DEPTH = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_reg;
    logic [NRD*DW-1:0]    rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [AW-1:0]        wr_reg;
    logic [DW-1:0]        wr_data;
    logic                 reg_write;
    logic                 reserve_en;
    logic [AW-1:0]        rsv_reg;
    logic                 ready;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_ready;
    int            m_init_cycles;

    always #5 clk = ~clk;

    regfile_scoreboard_mp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NRD)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .read_register_i    (rd_reg),
        .read_data_o        (rd_data),
        .read_busy_o        (rd_busy),
        .write_register_i   (wr_reg),
        .write_data_i       (wr_data),
        .reg_write_i        (reg_write),
        .reserve_en_i       (reserve_en),
        .reserve_register_i (rsv_reg),
        .ready_o            (ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] port_idx(input int p);
        return rd_reg[p*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] port_data(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic set_port(input int p, input int idx);
        rd_reg[p*AW +: AW] = AW'(idx);
    endtask

    task automatic idle();
        rst        = 1'b0;
        reg_write  = 1'b0;
        reserve_en = 1'b0;
        wr_reg     = '0;
        wr_data    = '0;
        rsv_reg    = '0;
    endtask

    // One rising edge as seen by the model.
    task automatic model_edge();
        if (rst) begin
            m_ready       = 1'b0;
            m_init_cycles = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else if (!m_ready) begin
            m_init_cycles++;
            if (m_init_cycles == DEPTH) m_ready = 1'b1;
        end else begin
            if (reg_write && wr_reg != 0) begin
                m_mem[wr_reg]  = wr_data;
                m_busy[wr_reg] = 1'b0;
            end
            if (reserve_en && rsv_reg != 0) m_busy[rsv_reg] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Compare every output against the model for the current cycle.
    task automatic check_all(input string tag);
        logic [DW-1:0] d;
        logic          b;
        logic [AW-1:0] idx;
        #1;
        chk({tag, ".ready"}, 64'(ready), 64'(m_ready));
        for (int p = 0; p < NRD; p++) begin
            idx = port_idx(p);
            d   = '0;
            b   = 1'b0;
            if (m_ready && idx != 0) begin
                d = m_mem[idx];
                b = m_busy[idx];
`ifdef REGFILE_BYPASS_EN
                if (reg_write && wr_reg == idx) begin
                    d = wr_data;
                    b = 1'b0;
                end
`endif
            end
            chk($sformatf("%s.p%0d.data", tag, p), 64'(port_data(p)), 64'(d));
            chk($sformatf("%s.p%0d.busy", tag, p), 64'(rd_busy[p]), 64'(b));
        end
    endtask

    task automatic step(input string tag);
        check_all(tag);
        tick();
    endtask

    task automatic randomize_inputs(input bit allow_reset);
        for (int p = 0; p < NRD; p++) begin
            if ($urandom_range(0, 3) == 0) set_port(p, $urandom_range(0, DEPTH-1));
            else                           set_port(p, $urandom_range(0, 7));
        end
        reg_write  = ($urandom_range(0, 1) == 1);
        wr_reg     = AW'($urandom_range(0, 7));
        wr_data    = $urandom;
        reserve_en = ($urandom_range(0, 2) == 0);
        rsv_reg    = ($urandom_range(0, 1) == 1) ? wr_reg : AW'($urandom_range(0, 7));
        rst        = allow_reset && ($urandom_range(0, 149) == 0);
    endtask

    initial begin
        int low_cycles;
        rd_reg = '0;
        idle();

        // ---- Init: first reset edge, then release ----
        rst = 1'b1;
        @(negedge clk);
        tick();
        step("rst_hold");
        rst = 1'b0;
        low_cycles = 0;
        for (int k = 0; k < DEPTH; k++) begin
            randomize_inputs(1'b0);
            #1;
            if (!ready) low_cycles++;
            step("init");
        end
        idle();
        #1;
        chk("init.low_cycles", 64'(low_cycles), 64'(DEPTH));
        chk("init.ready_cycle33", 64'(ready), 64'd1);
        for (int g = 0; g < DEPTH / NRD; g++) begin
            for (int p = 0; p < NRD; p++) set_port(p, g*NRD + p);
            check_all("init.zero");
            for (int p = 0; p < NRD; p++)
                chk($sformatf("init.zero.r%0d", g*NRD + p), 64'(port_data(p)), 64'd0);
        end

        // ---- Write / read ----
        reg_write = 1'b1; wr_reg = 5'd6; wr_data = 32'd10; step("wr6");
        wr_reg = 5'd7; wr_data = 32'd90;                   step("wr7");
        idle();
        set_port(0, 6); set_port(1, 7); set_port(2, 6); set_port(3, 7);
        check_all("rd67");
        chk("rd67.p0", 64'(port_data(0)), 64'd10);
        chk("rd67.p1", 64'(port_data(1)), 64'd90);
        tick();
        reg_write = 1'b1; wr_reg = 5'd0; wr_data = 32'hFFFF_FFFF; step("wr0");
        idle();
        set_port(0, 0);
        check_all("rd0");
        chk("rd0.zero", 64'(port_data(0)), 64'd0);
        tick();

        // ---- Scoreboard ----
        set_port(0, 10);
        reserve_en = 1'b1; rsv_reg = 5'd10; step("rsv10");
        idle();
        check_all("rsv10.after");
        chk("rsv10.busy", 64'(rd_busy[0]), 64'd1);
        reg_write = 1'b1; wr_reg = 5'd10; wr_data = 32'h55; step("wb10");
        idle();
        check_all("wb10.after");
        chk("wb10.busy", 64'(rd_busy[0]), 64'd0);
        chk("wb10.data", 64'(port_data(0)), 64'h55);
        reg_write = 1'b1; wr_reg = 5'd10; wr_data = 32'h77;
        reserve_en = 1'b1; rsv_reg = 5'd10;               step("rsvwb10");
        idle();
        check_all("rsvwb10.after");
        chk("rsvwb10.busy", 64'(rd_busy[0]), 64'd1);
        chk("rsvwb10.data", 64'(port_data(0)), 64'h77);
        reserve_en = 1'b1; rsv_reg = 5'd12;               step("rsv12");
        reserve_en = 1'b1; rsv_reg = 5'd11;
        reg_write = 1'b1; wr_reg = 5'd12; wr_data = 32'hC;  step("rsv11wb12");
        idle();
        set_port(1, 11); set_port(2, 12);
        check_all("diff.after");
        chk("diff.busy11", 64'(rd_busy[1]), 64'd1);
        chk("diff.busy12", 64'(rd_busy[2]), 64'd0);
        tick();

        // ---- Bypass ----
        set_port(0, 3);
        reg_write = 1'b1; wr_reg = 5'd3; wr_data = 32'h1234;
        check_all("byp.same");
`ifdef REGFILE_BYPASS_EN
        chk("byp.same.data", 64'(port_data(0)), 64'h1234);
`else
        chk("byp.same.data", 64'(port_data(0)), 64'h0);
`endif
        tick();
        idle();
        check_all("byp.next");
        chk("byp.next.data", 64'(port_data(0)), 64'h1234);
        tick();

        // ---- Multi-port ----
        reg_write = 1'b1; wr_reg = 5'd5; wr_data = 32'hA5A5; step("wr5");
        idle();
        reserve_en = 1'b1; rsv_reg = 5'd5;
        for (int p = 0; p < NRD; p++) set_port(p, 5);
        step("mp.rsv5");
        idle();
        check_all("mp");
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("mp.p%0d.data", p), 64'(port_data(p)), 64'hA5A5);
            chk($sformatf("mp.p%0d.busy", p), 64'(rd_busy[p]), 64'd1);
        end
        tick();

        // ---- Reset mid-operation ----
        reg_write = 1'b1; wr_reg = 5'd1; wr_data = 32'd40; step("wr1");
        idle();
        rst = 1'b1; step("midrst");
        rst = 1'b0;
        set_port(0, 1); set_port(1, 5); set_port(2, 10); set_port(3, 11);
        check_all("midrst.after");
        chk("midrst.ready", 64'(ready), 64'd0);
        chk("midrst.r1", 64'(port_data(0)), 64'd0);
        low_cycles = 0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            if (!ready) low_cycles++;
            step("midrst.init");
        end
        #1;
        chk("midrst.low_cycles", 64'(low_cycles), 64'(DEPTH));
        check_all("midrst.run");
        chk("midrst.r1.run", 64'(port_data(0)), 64'd0);
        chk("midrst.busy", 64'(rd_busy), 64'd0);
        tick();

        // ---- Random phase against the model ----
        for (int k = 0; k < 600; k++) begin
            randomize_inputs(1'b1);
            step("rand");
        end
        idle();
        check_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
